yarvi_soc: RTL and testbench

Minimal byte-stream SoC shell for simulation bring-up and board smoke tests. After reset it emits a fixed boot banner on the rx (SoC-to-host) stream. It then echoes every byte received on the tx (host-to-SoC) stream back out on rx, through a small FIFO. Both streams use valid/ready handshakes and sit directly on the host/UART bridge.

---
 rtl/yarvi_soc.sv | 145 ++++++++++++++
 tb/tb_yarvi_soc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_soc.sv
// Byte-stream SoC shell: boot banner on rx after reset, then echoes tx bytes
// back to rx through a small FIFO. Both streams use valid/ready handshakes.
module yarvi_soc #(
  parameter int FIFO_DEPTH = 4,
  parameter int BANNER_LEN = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       tx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data
);

  // Handshake: a byte moves on a rising edge where valid && ready; rx_valid and
  // rx_data are registered and held until accepted; tx_data is sampled only on
  // an accepted edge.

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = (BANNER_LEN > 2) ? $clog2(BANNER_LEN) : 1;

  typedef enum logic {
    ST_BANNER = 1'b0,
    ST_ECHO   = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            load;

  // ROM content is fixed text "YARVI\r\n".
  function automatic logic [7:0] banner_byte(input logic [IW-1:0] i);
    logic [7:0] b;
    case (i)
      IW'(0):  b = 8'h59;
      IW'(1):  b = 8'h41;
      IW'(2):  b = 8'h52;
      IW'(3):  b = 8'h56;
      IW'(4):  b = 8'h49;
      IW'(5):  b = 8'h0D;
      IW'(6):  b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign tx_ready   = !fifo_full;
  assign push       = tx_valid && !fifo_full;
  assign load       = !rx_valid_q || rx_ready;

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    pop        = 1'b0;
    case (state_q)
      ST_BANNER: begin
        if (load) begin
          rx_data_d  = banner_byte(idx_q);
          rx_valid_d = 1'b1;
          if (idx_q == IW'(BANNER_LEN - 1)) begin
            idx_d   = '0;
            state_d = ST_ECHO;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_ECHO: begin
        if (load) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            rx_data_d  = fifo_mem[rd_ptr_q];
            rx_valid_d = 1'b1;
          end else begin
            rx_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_BANNER;
      end
    endcase
  end

  // Pointers are power-of-two wide, so plain increment wraps modulo depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BANNER;
      idx_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_yarvi_soc.sv
// Scoreboard bench for yarvi_soc: banner, echo latency, backpressure,
// banner-time buffering, random streaming and mid-operation reset.
module tb_yarvi_soc;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] banner [7] = '{8'h59, 8'h41, 8'h52, 8'h56, 8'h49, 8'h0D, 8'h0A};

  yarvi_soc dut (
    .clock    (clock),
    .reset    (reset),
    .rx_ready (rx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data)
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compares every rx transfer and records every tx transfer
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("rx_hold_valid", rx_valid, 1);
        chk("rx_hold_data", rx_data, prev_data);
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %0h expected nothing", rx_data);
        end else begin
          chk("rx_stream", rx_data, exp_q.pop_front());
        end
      end
      if (tx_valid && tx_ready) exp_q.push_back(tx_data);
      prev_stall = rx_valid && !rx_ready;
      prev_data  = rx_data;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    #1;
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_tx_ready", tx_ready, 1);
    step();
    exp_q.delete();
    foreach (banner[i]) exp_q.push_back(banner[i]);
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int acc;
    int sent;
    int cyc;
    logic ok;
    logic [7:0] e4 [9];

    reset    = 1'b1;
    rx_ready = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // banner after reset, no gaps, then idle
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("banner_valid", rx_valid, 1);
      chk("banner_data", rx_data, banner[i]);
    end
    step();
    chk("post_banner_valid", rx_valid, 0);
    chk("post_banner_tx_ready", tx_ready, 1);

    // single echo latency
    tx_valid = 1'b1;
    tx_data  = 8'h41;
    step();
    tx_valid = 1'b0;
    step();
    chk("echo_valid", rx_valid, 1);
    chk("echo_data", rx_data, 8'h41);
    step();
    chk("echo_one_cycle", rx_valid, 0);

    // backpressure fills FIFO plus output register
    rx_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      tx_data  = 8'(8'h10 + acc);
      tx_valid = 1'b1;
      ok = tx_ready;
      step();
      if (ok) acc++;
    end
    chk("bp_accepts", acc, 5);
    chk("bp_tx_ready", tx_ready, 0);
    chk("bp_rx_valid", rx_valid, 1);
    chk("bp_rx_head", rx_data, 8'h10);
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    wait_drain(20);

    // bytes received during banner follow it without a gap
    e4 = '{8'h59, 8'h41, 8'h52, 8'h56, 8'h49, 8'h0D, 8'h0A, 8'hAA, 8'hBB};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tx_valid = (i < 2);
      tx_data  = (i == 0) ? 8'hAA : 8'hBB;
      step();
      chk("banner_then_echo_valid", rx_valid, 1);
      chk("banner_then_echo_data", rx_data, e4[i]);
    end
    tx_valid = 1'b0;
    step();
    chk("banner_then_echo_idle", rx_valid, 0);

    // random streaming with random rx backpressure
    sent = 0;
    cyc  = 0;
    while (sent < 64 && cyc < 3000) begin
      rx_ready = 1'($urandom_range(0, 1));
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom_range(0, 255));
      ok = tx_valid && tx_ready;
      step();
      if (ok) sent++;
      cyc++;
    end
    chk("random_sent", sent, 64);
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    wait_drain(40);

    // reset mid-banner discards queued bytes and restarts banner
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tx_valid = (i < 2);
      tx_data  = (i == 0) ? 8'h33 : 8'h44;
      step();
    end
    tx_valid = 1'b0;
    chk("mid_rx_data_before_reset", rx_data, 8'h56);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("restart_banner_valid", rx_valid, 1);
      chk("restart_banner_data", rx_data, banner[i]);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("restart_no_stale", rx_valid, 0);
    end
    chk("restart_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
